// File: rtl/fir_stream_driver.sv
// fir_stream_driver
// -----------------------------------------------------------------------------
// Initiator for the FIR filter's strobe/done interface. Samples from an
// upstream valid/ready stream are queued in a small FIFO. Each sample is sent
// to the filter as a one-cycle strobe. The driver then follows the filter's
// done_flag as it falls and rises again, samples the 32-bit result and offers
// it on a downstream valid/ready stream. Only one sample is in flight at a time.
//
// Parameters
//   DEPTH    input FIFO entries (power of 2, >= 2)
//   SETTLE   cycles between the done rise and the sampling of fir_result (0..7)
//   TIMEOUT  cycles allowed across WAIT_LOW + WAIT_HIGH before abort (>= 8)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   s_data      signed input sample            s_valid / s_ready  upstream handshake
//   fir_data    sample presented to the filter fir_flag           one-cycle strobe
//   fir_done    filter done_flag (1 = idle)    fir_result         filter output
//   m_result    captured result                m_valid / m_ready  downstream handshake
//   m_timeout   one-cycle pulse on an aborted transaction
//   busy        FSM not idle or FIFO not empty
// -----------------------------------------------------------------------------
module fir_stream_driver #(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  fir_data,
    output logic        fir_flag,
    input  logic        fir_done,
    input  logic [31:0] fir_result,
    output logic [31:0] m_result,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_timeout,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] COUNT_FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT - 1);
    localparam logic [2:0]    SETTLE_INIT = 3'(SETTLE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        SETTLE_W  = 3'd4,
        HOLD      = 3'd5
    } state_t;

    state_t         state_reg, state_next;

    logic [7:0]     fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;

    logic [7:0]     fir_data_reg;
    logic [31:0]    m_result_reg;
    logic           m_valid_reg;
    logic           m_timeout_reg;
    logic [TW-1:0]  tcnt_reg, tcnt_next;
    logic [2:0]     settle_reg, settle_next;

    logic           push;
    logic           pop;
    logic           capture;
    logic           timeout_hit;

    // -------------------------------------------------------------------------
    // Upstream side
    // -------------------------------------------------------------------------
    assign s_ready = (count_reg != COUNT_FULL);
    assign push    = s_valid && s_ready;

    // Storage has no reset; only the pointers and count define its content.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tcnt_reg   <= '0;
            settle_reg <= '0;
        end else begin
            state_reg  <= state_next;
            tcnt_reg   <= tcnt_next;
            settle_reg <= settle_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        tcnt_next   = tcnt_reg;
        settle_next = settle_reg;
        pop         = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;

        case (state_reg)
            IDLE: begin
                // The filter must report idle before anything is issued, which
                // also covers a filter still busy after an aborted transaction.
                if ((count_reg != '0) && fir_done && !m_valid_reg) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                tcnt_next  = '0;
                state_next = WAIT_LOW;
            end

            // The timeout budget is shared by both wait states. The compare is
            // ">=" because the count may already sit at the limit when the
            // FSM moves on to WAIT_HIGH.
            WAIT_LOW: begin
                if (!fir_done) begin
                    tcnt_next  = tcnt_reg + TW'(1);
                    state_next = WAIT_HIGH;
                end else if (tcnt_reg >= TIMEOUT_END) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end

            WAIT_HIGH: begin
                if (fir_done) begin
                    settle_next = SETTLE_INIT;
                    state_next  = SETTLE_W;
                end else if (tcnt_reg >= TIMEOUT_END) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end

            // fir_result is sampled in the cycle when the counter reads zero.
            // With SETTLE=0 that is the first SETTLE_W cycle.
            SETTLE_W: begin
                if (settle_reg == 3'd0) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end else begin
                    settle_next = settle_reg - 3'd1;
                end
            end

            HOLD: begin
                if (m_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Filter side and downstream registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fir_data_reg  <= '0;
            m_result_reg  <= '0;
            m_valid_reg   <= 1'b0;
            m_timeout_reg <= 1'b0;
        end else begin
            // Registered FIFO read. It is held until the next issue.
            if (pop) begin
                fir_data_reg <= fifo_mem[rd_ptr_reg];
            end
            if (capture) begin
                m_result_reg <= fir_result;
                m_valid_reg  <= 1'b1;
            end else if ((state_reg == HOLD) && m_ready) begin
                m_valid_reg <= 1'b0;
            end
            m_timeout_reg <= timeout_hit;
        end
    end

    assign fir_data  = fir_data_reg;
    assign fir_flag  = (state_reg == ISSUE);
    assign m_result  = m_result_reg;
    assign m_valid   = m_valid_reg;
    assign m_timeout = m_timeout_reg;
    assign busy      = (state_reg != IDLE) || (count_reg != '0);

endmodule
